dmac_cfg_apb: RTL and testbench

DMAC_CFG_APB -- requirements
Module: dmac_cfg_apb

---
 rtl/dmac_pkg.sv | 47 ++++
 rtl/dmac_cfg_apb.sv | 131 +++++++++++++
 tb/tb_dmac_cfg_apb.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_pkg.sv
// ============================================================================
// dmac_pkg : register map, identification constant and STAT bit positions
// Rev 1.0
// ============================================================================
`default_nettype none

package dmac_pkg;

  localparam logic [11:0] VER_OFF  = 12'h000;
  localparam logic [11:0] SRC_OFF  = 12'h100;
  localparam logic [11:0] DST_OFF  = 12'h104;
  localparam logic [11:0] LEN_OFF  = 12'h108;
  localparam logic [11:0] CMD_OFF  = 12'h10C;
  localparam logic [11:0] STAT_OFF = 12'h110;

  localparam logic [31:0] VER_VALUE = 32'h0001_2024;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int CMD_START_BIT = 0;

  typedef enum logic [2:0] {
    REG_VER  = 3'd0,
    REG_SRC  = 3'd1,
    REG_DST  = 3'd2,
    REG_LEN  = 3'd3,
    REG_CMD  = 3'd4,
    REG_STAT = 3'd5,
    REG_NONE = 3'd6
  } reg_sel_e;

  // Word-address decode; byte-lane bits never reach this function.
  function automatic reg_sel_e decode_reg(input logic [9:0] word);
    reg_sel_e sel;
    sel = REG_NONE;
    if (word == VER_OFF[11:2])  sel = REG_VER;
    if (word == SRC_OFF[11:2])  sel = REG_SRC;
    if (word == DST_OFF[11:2])  sel = REG_DST;
    if (word == LEN_OFF[11:2])  sel = REG_LEN;
    if (word == CMD_OFF[11:2])  sel = REG_CMD;
    if (word == STAT_OFF[11:2]) sel = REG_STAT;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmac_cfg_apb.sv
// ============================================================================
// dmac_cfg_apb : APB configuration slave for the DMA engine (one wait state)
// Rev 1.0
// ============================================================================
`default_nettype none

module dmac_cfg_apb
  import dmac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [11:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o,
  output logic [31:0] src_addr_o,
  output logic [31:0] dst_addr_o,
  output logic [15:0] byte_len_o,
  output logic        start_o,
  input  logic        done_i
);

  logic        pready_q, pslverr_q, armed_q;
  logic [31:0] prdata_q;
  logic [31:0] src_q, src_d, dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic        busy_q, busy_d, done_q, done_d, start_q, start_d;

  reg_sel_e    sel;
  logic        err;
  logic [31:0] rdata;
  logic        wait_edge;
  logic        commit;
  logic        unused_ok;

  assign unused_ok = &{1'b0, paddr_i[1:0]};

  always_comb begin
    sel   = decode_reg(paddr_i[11:2]);
    err   = (sel == REG_NONE) | (pwrite_i & (sel == REG_VER)) | (~pwrite_i & (sel == REG_CMD));
    rdata = '0;
    case (sel)
      REG_VER:  rdata = VER_VALUE;
      REG_SRC:  rdata = src_q;
      REG_DST:  rdata = dst_q;
      REG_LEN:  rdata = {16'h0000, len_q};
      REG_STAT: begin
        rdata[STAT_BUSY_BIT] = busy_q;
        rdata[STAT_DONE_BIT] = done_q;
      end
      default:  rdata = '0;
    endcase
  end

  // armed_q demands a fresh setup phase, so a transfer cut short by reset never resumes.
  assign wait_edge = psel_i & penable_i & ~pready_q & armed_q;
  assign commit    = psel_i & penable_i & pwrite_i & pready_q & ~err;

  always_ff @(posedge clk) begin
    if (rst) begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      pready_q  <= wait_edge;
      prdata_q  <= (wait_edge & ~err) ? rdata : '0;
      pslverr_q <= wait_edge & err;
      if (psel_i & ~penable_i) armed_q <= 1'b1;
      else if (pready_q)       armed_q <= 1'b0;
    end
  end

  always_comb begin
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    busy_d  = busy_q;
    done_d  = done_q;
    start_d = 1'b0;
    if (commit) begin
      case (sel)
        REG_SRC:  if (!busy_q) src_d = pwdata_i;
        REG_DST:  if (!busy_q) dst_d = pwdata_i;
        REG_LEN:  if (!busy_q) len_d = pwdata_i[15:0];
        REG_CMD:  if (pwdata_i[CMD_START_BIT] && !busy_q && (len_q != 16'h0000)) start_d = 1'b1;
        REG_STAT: if (pwdata_i[STAT_DONE_BIT]) done_d = 1'b0;
        default:  ;
      endcase
    end
    // Completion overrides a same-cycle W1C; the start guard already saw pre-edge busy.
    if (done_i) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
    if (start_d) busy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  assign pready_o   = pready_q;
  assign prdata_o   = prdata_q;
  assign pslverr_o  = pslverr_q;
  assign src_addr_o = src_q;
  assign dst_addr_o = dst_q;
  assign byte_len_o = len_q;
  assign start_o    = start_q;

endmodule

`default_nettype wire

// File: tb/tb_dmac_cfg_apb.sv
// ============================================================================
// tb_dmac_cfg_apb : directed + randomized bench against a register-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmac_cfg_apb;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite, done_i;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pready_o, pslverr_o, start_o;
  logic [31:0] prdata_o, src_addr_o, dst_addr_o;
  logic [15:0] byte_len_o;

  dmac_cfg_apb dut (
    .clk(clk), .rst(rst),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata),
    .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .byte_len_o(byte_len_o),
    .start_o(start_o), .done_i(done_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register-level reference model ----------------
  logic [31:0] m_src, m_dst;
  logic [15:0] m_len;
  logic        m_busy, m_done, exp_start;
  logic        commit_req = 1'b0, snap_req = 1'b0;
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic        chk_en = 1'b0;
  logic        prev_pready = 1'b0;

  function automatic logic ref_err(input logic wr, input logic [11:0] a);
    logic [11:0] w;
    w = {a[11:2], 2'b00};
    case (w)
      12'h000: return wr;
      12'h100, 12'h104, 12'h108, 12'h110: return 1'b0;
      12'h10C: return ~wr;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [11:0] a);
    logic [11:0] w;
    w = {a[11:2], 2'b00};
    case (w)
      12'h000: return 32'h0001_2024;
      12'h100: return m_src;
      12'h104: return m_dst;
      12'h108: return {16'h0, m_len};
      12'h110: return {30'h0, m_done, m_busy};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic        accept, pre_busy;
    logic [11:0] w;
    if (rst) begin
      m_src = 0; m_dst = 0; m_len = 0; m_busy = 0; m_done = 0; exp_start = 0;
      exp_rdata = 0; exp_err = 0; commit_req = 0; snap_req = 0;
    end else begin
      if (snap_req) begin
        exp_err   = ref_err(pwrite, paddr);
        exp_rdata = exp_err ? 32'h0 : ref_read(paddr);
        snap_req  = 0;
      end
      accept   = 0;
      pre_busy = m_busy;
      w = {paddr[11:2], 2'b00};
      if (commit_req && !ref_err(1'b1, paddr)) begin
        if (w == 12'h100 && !pre_busy) m_src = pwdata;
        if (w == 12'h104 && !pre_busy) m_dst = pwdata;
        if (w == 12'h108 && !pre_busy) m_len = pwdata[15:0];
        if (w == 12'h10C && pwdata[0] && !pre_busy && m_len != 0) accept = 1;
        if (w == 12'h110 && pwdata[1]) m_done = 0;
      end
      if (done_i) begin m_done = 1; m_busy = 0; end
      if (accept) m_busy = 1;
      exp_start  = accept;
      commit_req = 0;
    end
  end

  // per-cycle comparison of every engine-side output and APB idle values
  always @(negedge clk) begin
    if (chk_en) begin
      check("src_addr_o", src_addr_o, m_src);
      check("dst_addr_o", dst_addr_o, m_dst);
      check("byte_len_o", {16'h0, byte_len_o}, {16'h0, m_len});
      check("start_o", {31'h0, start_o}, {31'h0, exp_start});
      if (!pready_o) check("idle_rdata_err", {prdata_o[31:1], prdata_o[0] | pslverr_o}, 32'h0);
      if (pready_o && prev_pready) check("pready_single_cycle", 32'h1, 32'h0);
      prev_pready = pready_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d, input logic dn,
                     output logic [31:0] rd, output logic er);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    rd = 0; er = 0;
    @(posedge clk); #1 penable = 1;
    @(negedge clk);
    check("pready_wait_state", {31'h0, pready_o}, 32'h0);
    snap_req = 1;
    @(negedge clk);
    check("pready_rise", {31'h0, pready_o}, 32'h1);
    if (!pready_o) begin
      @(posedge clk); #1 psel = 0; penable = 0;
      return;
    end
    check("prdata_o", prdata_o, exp_rdata);
    check("pslverr_o", {31'h0, pslverr_o}, {31'h0, exp_err});
    rd = prdata_o; er = pslverr_o;
    commit_req = wr;
    if (dn) done_i = 1;
    @(posedge clk); #1;
    done_i = 0; psel = 0; penable = 0;
  endtask

  task automatic idle(input int n, input logic dn);
    for (int i = 0; i < n; i++) begin
      done_i = dn;
      @(posedge clk); #1 done_i = 0;
    end
  endtask

  logic [11:0] addr_tab [9] = '{12'h000, 12'h100, 12'h104, 12'h108, 12'h10C,
                                12'h110, 12'h1FC, 12'h114, 12'hFFC};

  initial begin
    logic [31:0] rd;
    logic        er;
    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; done_i = 0;
    @(posedge clk); #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pready", {31'h0, pready_o}, 32'h0);
    check("reset_src", src_addr_o, 32'h0);
    check("reset_start", {31'h0, start_o}, 32'h0);
    rst = 0;
    idle(2, 0);

    // write/read
    apb(1, 12'h100, 32'h0123_4567, 0, rd, er); check("wr_src_err", {31'h0, er}, 32'h0);
    apb(0, 12'h100, 32'h0, 0, rd, er);          check("rd_src", rd, 32'h0123_4567);
    check("rd_src_err", {31'h0, er}, 32'h0);

    // start / done / W1C
    apb(1, 12'h108, 32'h0000_0040, 0, rd, er);
    apb(1, 12'h10C, 32'h1, 0, rd, er);          check("start_pulse", {31'h0, start_o}, 32'h1);
    apb(0, 12'h110, 32'h0, 0, rd, er);          check("stat_busy", rd, 32'h1);
    idle(1, 1);
    apb(0, 12'h110, 32'h0, 0, rd, er);          check("stat_done", rd, 32'h2);
    apb(1, 12'h110, 32'h2, 0, rd, er);
    apb(0, 12'h110, 32'h0, 0, rd, er);          check("stat_w1c", rd, 32'h0);

    // guards
    apb(1, 12'h108, 32'h0, 0, rd, er);
    apb(1, 12'h10C, 32'h1, 0, rd, er);          check("no_start_len0", {31'h0, start_o}, 32'h0);
    apb(0, 12'h110, 32'h0, 0, rd, er);          check("stat_len0", rd, 32'h0);
    apb(1, 12'h108, 32'h40, 0, rd, er);
    apb(1, 12'h10C, 32'h1, 0, rd, er);
    apb(1, 12'h104, 32'hFFFF_FFFF, 0, rd, er);  check("busy_wr_err", {31'h0, er}, 32'h0);
    apb(0, 12'h104, 32'h0, 0, rd, er);          check("dst_unchanged", rd, 32'h0);
    apb(1, 12'h10C, 32'h1, 0, rd, er);          check("no_restart_busy", {31'h0, start_o}, 32'h0);

    // collisions
    apb(1, 12'h10C, 32'h1, 1, rd, er);          check("coll_no_start", {31'h0, start_o}, 32'h0);
    apb(0, 12'h110, 32'h0, 0, rd, er);          check("coll_stat", rd, 32'h2);
    apb(1, 12'h110, 32'h2, 1, rd, er);
    apb(0, 12'h110, 32'h0, 0, rd, er);          check("w1c_coll_stat", rd, 32'h2);

    // errors
    apb(0, 12'h1FC, 32'h0, 0, rd, er);          check("unmapped_err", {31'h0, er}, 32'h1);
    check("unmapped_rdata", rd, 32'h0);
    apb(1, 12'h000, 32'hDEAD_BEEF, 0, rd, er);  check("wr_ver_err", {31'h0, er}, 32'h1);
    apb(0, 12'h003, 32'h0, 0, rd, er);          check("rd_ver", rd, 32'h0001_2024);
    apb(1, 12'h108, 32'hABCD_1234, 0, rd, er);
    apb(0, 12'h108, 32'h0, 0, rd, er);          check("rd_len", rd, 32'h0000_1234);
    apb(0, 12'h10C, 32'h0, 0, rd, er);          check("rd_cmd_err", {31'h0, er}, 32'h1);

    // reset mid-transfer
    apb(1, 12'h100, 32'hDEAD_0000, 0, rd, er);
    psel = 1; penable = 0; pwrite = 0; paddr = 12'h100;
    @(posedge clk); #1 penable = 1; rst = 1;
    @(posedge clk); #1;
    check("rst_mid_pready", {31'h0, pready_o}, 32'h0);
    check("rst_mid_src", src_addr_o, 32'h0);
    check("rst_mid_rdata", prdata_o, 32'h0);
    rst = 0; psel = 0; penable = 0;
    idle(1, 0);
    apb(0, 12'h100, 32'h0, 0, rd, er);          check("rd_src_after_rst", rd, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = addr_tab[$urandom_range(0, 8)] | 12'($urandom_range(0, 3));
      d = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 1) == 1) d[0] = 1'b1;
      apb($urandom_range(0, 1) == 1, a, d, $urandom_range(0, 6) == 0, rd, er);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), $urandom_range(0, 4) == 0);
    end
    idle(3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
